// File: rtl/a4_pkg.sv
// Stage encodings, divide next-state function and crosspoint table for A4.
// Latency: pure functions and constants, no state.
// Backpressure: none; nothing in this package holds state.
package a4_pkg;

  typedef enum logic [2:0] {
    STG_0 = 3'd0, STG_1 = 3'd1, STG_2 = 3'd2, STG_3 = 3'd3,
    STG_4 = 3'd4, STG_5 = 3'd5, STG_6 = 3'd6, STG_7 = 3'd7
  } stg_e;

  // Membership masks indexed by stage number.
  localparam logic [7:0] ST376_SET  = 8'b1100_1000;
  localparam logic [7:0] ST1376_SET = 8'b1100_1010;
  localparam logic [7:0] ST3764_SET = 8'b1101_1000;

  function automatic logic in_set(input stg_e s, input logic [7:0] set);
    return set[s];
  endfunction

  // Divide sequence 0->1->3->7->6->4->0; unused codes fall back to 0.
  function automatic stg_e div_next(input stg_e s);
    case (s)
      STG_0:   return STG_1;
      STG_1:   return STG_3;
      STG_3:   return STG_7;
      STG_7:   return STG_6;
      STG_6:   return STG_4;
      default: return STG_0;
    endcase
  endfunction

  // Terms the crosspoint matrix is built from; all active high.
  typedef struct packed {
    logic [12:1] t;
    logic div, st0, st1, st3, st4, st376, st1376;
    logic br1, br2;
    logic read0, write0, rand0, wand0, ror0, wor0, rxor0, rupt0, rupt1;
    logic geqzro, l15, sumb16, trsm, rsm3, mp1, ts0, store1;
  } xp_in_t;

  // Control pulses and crosspoints, active high (ports invert the _ forms).
  typedef struct packed {
    logic ra, rb, rc, rb1, r1c, wg, wl, wy, ci, l16, rsc, wch, tmz;
    logic tsgn, tsgn2, trsm, tl15;
    logic b15x, r15, rb2, rrpa, sgum, t12use;
    logic d1xp10, d2xp3, d2xp5, d3xp7, d5xp4, d6xp5, d7xp19, d8xp6, d9xp1;
    logic d2pp1, d8pp4;
  } xp_out_t;

  function automatic xp_out_t xp_eval(input xp_in_t i);
    xp_out_t o;
    logic dv0, dv1, dv4, dv376, dv1376, io;
    dv0    = i.div & i.st0;
    dv1    = i.div & i.st1;
    dv4    = i.div & i.st4;
    dv376  = i.div & i.st376;
    dv1376 = i.div & i.st1376;
    io     = i.read0 | i.write0 | i.rand0 | i.wand0 | i.ror0 | i.wor0 | i.rxor0;
    o = '0;
    o.d1xp10 = i.t[1] & dv0;
    o.d2xp3  = i.t[2] & i.st3;
    o.d2xp5  = i.t[2] & dv1;
    o.d3xp7  = i.t[3] & dv376;
    o.d5xp4  = i.t[5] & dv4;
    o.d6xp5  = i.t[6] & dv376 & i.br1;
    o.d7xp19 = i.t[7] & dv1376 & !i.br1 & !i.br2;
    o.d8xp6  = i.t[8] & dv4 & i.br1 & i.br2;
    o.d9xp1  = i.t[9] & i.st0 & i.rupt0;
    o.d2pp1  = i.t[2] & dv1376 & i.br1 & !i.br2;
    o.d8pp4  = i.t[8] & dv376 & !i.br1;
    o.b15x   = i.t[7] & dv0;
    o.r15    = i.t[1] & i.rupt1;
    o.rb2    = i.t[3] & i.rupt0;
    o.rrpa   = i.t[10] & i.rupt1;
    o.sgum   = i.t[4] & dv376 & (i.br1 ^ i.br2);
    o.t12use = i.t[12] & dv1376;
    o.tsgn   = i.t[1] & i.div & i.st0;
    o.tsgn2  = i.t[4] & dv376 & i.sumb16;
    o.ra     = (i.t[1] & io) | o.r15 | (i.t[2] & i.rupt0);
    o.rb     = (o.d2xp3 & !i.div) | (i.t[5] & dv1376);
    o.rc     = i.t[4] & dv376 & !i.geqzro;
    o.rb1    = (i.t[9] & dv1) | o.rb2;
    o.r1c    = i.t[6] & dv4;
    o.wg     = (i.t[5] & (i.read0 | i.rand0 | i.ror0 | i.rxor0)) | o.d2xp5;
    o.wl     = i.t[8] & io;
    o.wy     = (i.t[6] & io) | o.d3xp7;
    o.ci     = i.t[7] & dv1376 & !i.br1;
    o.l16    = i.t[8] & dv4 & i.l15;
    o.rsc    = i.t[2] & (i.read0 | i.write0);
    o.wch    = i.t[8] & (i.write0 | i.wand0 | i.wor0);
    o.tmz    = i.t[10] & i.st0 & i.store1;
    o.trsm   = i.t[5] & i.trsm & i.rsm3;
    o.tl15   = (i.t[11] & i.st1 & i.mp1) | (i.t[3] & i.ts0);
    return o;
  endfunction

endpackage

// File: rtl/a4_stage_branch_if.sv
// Signal bundle between the SQ/QC decoder side and the A4 stage/branch module.
// Latency: wires only.
// Backpressure: none; all signals are level/pulse control lines.
interface a4_stage_branch_if;
  logic CGA4, DVST, GOJAM, RSTSTG, STRTFC;
  logic SQ0_, SQ1_, SQ2_, SQEXT, SQEXT_, SQR10, SQR10_, SQR12_, QC0_, QC1_, QC2_, QC3_;
  logic T01, T01_, T02_, T03_, T04_, T05_, T06_, T07_, T08_, T09_, T10_, T11_, T12_;
  logic PHS2_, PHS3_, PHS4, PHS4_, ST1, ST2;
  logic SUMA16_, SUMB16_, OVF_, UNF_, GEQZRO_, L15_, TOV_, TPZG_, TSGU_;
  logic WL01_, WL02_, WL03_, WL04_, WL05_, WL06_, WL07_, WL08_;
  logic WL09_, WL10_, WL11_, WL12_, WL13_, WL14_, WL15_, WL16_;
  logic EXST0_, EXST1_, IC12, IC13, INKL, MP0_, MP1, MP3_, MTCSAI, NDR100_;
  logic RSM3, RSM3_, STORE1_, TRSM, TS0_, XB7_, XT1_, d7XP14;

  logic STG1, STG2, STG3, ST0_, ST1_, ST3_, ST4_, ST1D, STD2, ST376, ST376_, ST1376_;
  logic BR1, BR1_, BR2, BR2_, BR12B, BR12B_, BR1B2, BR1B2_, BR1B2B, BR1B2B_, BRDIF_;
  logic DIV_, DIVSTG, DV0, DV0_, DV1, DV1_, DV4, DV4_, DV376, DV376_, DV1376, DV1376_, DV3764, DVST_;
  logic READ0, READ0_, WRITE0, WRITE0_, RAND0, WAND0, ROR0, WOR0, WOR0_, RXOR0, RXOR0_;
  logic RUPT0, RUPT0_, RUPT1, RUPT1_, INOUT, INOUT_, PRINC, KRPT;
  logic RA_, RB_, RC_, RB1_, R1C_, WG_, WL_, WY_, CI_, L16_, RSC_, WCH_, TMZ_, TSGN_, TSGN2, TRSM_, TL15;
  logic MBR1, MBR2, MST1, MST2, MST3, MRSC, MP3A, MP0T10;
  logic B15X, R15, RB2, RRPA, SGUM, T12USE_;
  logic d1XP10, d2XP3, d2XP5, d3XP7, d5XP4, d6XP5, d7XP19, d8XP6, d9XP1, d2PP1, d8PP4;

  modport master (
    output CGA4, DVST, GOJAM, RSTSTG, STRTFC,
    output SQ0_, SQ1_, SQ2_, SQEXT, SQEXT_, SQR10, SQR10_, SQR12_, QC0_, QC1_, QC2_, QC3_,
    output T01, T01_, T02_, T03_, T04_, T05_, T06_, T07_, T08_, T09_, T10_, T11_, T12_,
    output PHS2_, PHS3_, PHS4, PHS4_, ST1, ST2,
    output SUMA16_, SUMB16_, OVF_, UNF_, GEQZRO_, L15_, TOV_, TPZG_, TSGU_,
    output WL01_, WL02_, WL03_, WL04_, WL05_, WL06_, WL07_, WL08_,
    output WL09_, WL10_, WL11_, WL12_, WL13_, WL14_, WL15_, WL16_,
    output EXST0_, EXST1_, IC12, IC13, INKL, MP0_, MP1, MP3_, MTCSAI, NDR100_,
    output RSM3, RSM3_, STORE1_, TRSM, TS0_, XB7_, XT1_, d7XP14,
    input  STG1, STG2, STG3, ST0_, ST1_, ST3_, ST4_, ST1D, STD2, ST376, ST376_, ST1376_,
    input  BR1, BR1_, BR2, BR2_, BR12B, BR12B_, BR1B2, BR1B2_, BR1B2B, BR1B2B_, BRDIF_,
    input  DIV_, DIVSTG, DV0, DV0_, DV1, DV1_, DV4, DV4_, DV376, DV376_, DV1376, DV1376_, DV3764, DVST_,
    input  READ0, READ0_, WRITE0, WRITE0_, RAND0, WAND0, ROR0, WOR0, WOR0_, RXOR0, RXOR0_,
    input  RUPT0, RUPT0_, RUPT1, RUPT1_, INOUT, INOUT_, PRINC, KRPT,
    input  RA_, RB_, RC_, RB1_, R1C_, WG_, WL_, WY_, CI_, L16_, RSC_, WCH_, TMZ_, TSGN_, TSGN2, TRSM_, TL15,
    input  MBR1, MBR2, MST1, MST2, MST3, MRSC, MP3A, MP0T10,
    input  B15X, R15, RB2, RRPA, SGUM, T12USE_,
    input  d1XP10, d2XP3, d2XP5, d3XP7, d5XP4, d6XP5, d7XP19, d8XP6, d9XP1, d2PP1, d8PP4
  );

  modport slave (
    input  CGA4, DVST, GOJAM, RSTSTG, STRTFC,
    input  SQ0_, SQ1_, SQ2_, SQEXT, SQEXT_, SQR10, SQR10_, SQR12_, QC0_, QC1_, QC2_, QC3_,
    input  T01, T01_, T02_, T03_, T04_, T05_, T06_, T07_, T08_, T09_, T10_, T11_, T12_,
    input  PHS2_, PHS3_, PHS4, PHS4_, ST1, ST2,
    input  SUMA16_, SUMB16_, OVF_, UNF_, GEQZRO_, L15_, TOV_, TPZG_, TSGU_,
    input  WL01_, WL02_, WL03_, WL04_, WL05_, WL06_, WL07_, WL08_,
    input  WL09_, WL10_, WL11_, WL12_, WL13_, WL14_, WL15_, WL16_,
    input  EXST0_, EXST1_, IC12, IC13, INKL, MP0_, MP1, MP3_, MTCSAI, NDR100_,
    input  RSM3, RSM3_, STORE1_, TRSM, TS0_, XB7_, XT1_, d7XP14,
    output STG1, STG2, STG3, ST0_, ST1_, ST3_, ST4_, ST1D, STD2, ST376, ST376_, ST1376_,
    output BR1, BR1_, BR2, BR2_, BR12B, BR12B_, BR1B2, BR1B2_, BR1B2B, BR1B2B_, BRDIF_,
    output DIV_, DIVSTG, DV0, DV0_, DV1, DV1_, DV4, DV4_, DV376, DV376_, DV1376, DV1376_, DV3764, DVST_,
    output READ0, READ0_, WRITE0, WRITE0_, RAND0, WAND0, ROR0, WOR0, WOR0_, RXOR0, RXOR0_,
    output RUPT0, RUPT0_, RUPT1, RUPT1_, INOUT, INOUT_, PRINC, KRPT,
    output RA_, RB_, RC_, RB1_, R1C_, WG_, WL_, WY_, CI_, L16_, RSC_, WCH_, TMZ_, TSGN_, TSGN2, TRSM_, TL15,
    output MBR1, MBR2, MST1, MST2, MST3, MRSC, MP3A, MP0T10,
    output B15X, R15, RB2, RRPA, SGUM, T12USE_,
    output d1XP10, d2XP3, d2XP5, d3XP7, d5XP4, d6XP5, d7XP19, d8XP6, d9XP1, d2PP1, d8PP4
  );
endinterface

// File: rtl/a4_stage_reg.sv
// Stage counter STG3..1 with the divide-stage sequencer.
// Latency: stage updates one clock after a stage strobe; divstg is combinational.
// Backpressure: none; the counter only moves on the stage strobe.
module a4_stage_reg
  import a4_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ss,       // stage strobe
  input  logic clr,      // GOJAM | RSTSTG | STRTFC
  input  logic div,
  input  logic dvst,
  input  logic st1_req,
  input  logic st2_req,
  output stg_e stg,
  output logic divstg
);

  // Divide sequencing is live in stage 0 and along 1,3,7,6; stage 4 exits normally.
  assign divstg = div & ((stg == STG_0) | in_set(stg, ST1376_SET));

  // Stage register: clear beats divide stepping, which beats the ST1/ST2 load.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg <= STG_0;
    end else if (ss) begin
      if (clr)                 stg <= STG_0;
      else if (divstg && dvst) stg <= div_next(stg);
      else                     stg <= stg_e'({1'b0, st2_req, st1_req});
    end
  end

endmodule

// File: rtl/a4_stage_branch.sv
// AGC A4 stage/branch: stage and branch state, class decodes, crosspoint pulses.
// Latency: STG/BR register on CLOCK; every other output is combinational.
// Backpressure: none; outputs follow inputs and state each cycle.
module a4_stage_branch
  import a4_pkg::*;
(
  input logic               CLOCK,
  input logic               rst,
  a4_stage_branch_if.slave  bus
);

  stg_e        stg;
  logic [2:0]  stg_bits;
  logic        divstg, div, ss, stg_clr;
  logic        br1, br2, wl_zero;
  logic        st0_d, st1_d, st2_d, st3_d, st4_d, st376_d, st1376_d, st3764_d;
  logic        io, rupt0;
  logic [2:0]  io_idx;
  logic [7:0]  cls;
  xp_in_t      xi;
  xp_out_t     xo;
  logic        unused_ok;

  assign ss      = !bus.T12_ & !bus.PHS3_;
  assign stg_clr = bus.GOJAM | bus.RSTSTG | bus.STRTFC;
  assign div     = bus.SQEXT & !bus.SQ1_ & !bus.QC0_;

  a4_stage_reg u_stage (
    .clk     (CLOCK),
    .rst     (rst),
    .ss      (ss),
    .clr     (stg_clr),
    .div     (div),
    .dvst    (bus.DVST),
    .st1_req (bus.ST1),
    .st2_req (bus.ST2),
    .stg     (stg),
    .divstg  (divstg)
  );

  assign wl_zero = &{bus.WL16_, bus.WL15_, bus.WL14_, bus.WL13_, bus.WL12_, bus.WL11_,
                     bus.WL10_, bus.WL09_, bus.WL08_, bus.WL07_, bus.WL06_, bus.WL05_,
                     bus.WL04_, bus.WL03_, bus.WL02_, bus.WL01_};

  // Branch flops: later tests override earlier ones on the same edge, GOJAM last.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      br1 <= 1'b0;
      br2 <= 1'b0;
    end else begin
      if (!bus.TOV_) begin
        br1 <= !bus.OVF_;
        br2 <= !bus.UNF_;
      end
      if (!bus.TSGU_) br1 <= !bus.SUMA16_;
      if (!bus.TPZG_) br2 <= wl_zero;
      if (bus.GOJAM) begin
        br1 <= 1'b0;
        br2 <= 1'b0;
      end
    end
  end

  assign stg_bits = stg;
  assign st0_d    = (stg == STG_0);
  assign st1_d    = (stg == STG_1);
  assign st2_d    = (stg == STG_2);
  assign st3_d    = (stg == STG_3);
  assign st4_d    = (stg == STG_4);
  assign st376_d  = in_set(stg, ST376_SET);
  assign st1376_d = in_set(stg, ST1376_SET);
  assign st3764_d = in_set(stg, ST3764_SET);

  // Peripheral class decode: one-hot over {QC1,QC0,SQR10}, class 7 is RUPT1.
  assign io     = bus.SQEXT & !bus.SQ0_;
  assign io_idx = {!bus.QC1_, !bus.QC0_, bus.SQR10};
  assign cls    = io ? (8'd1 << io_idx) : 8'd0;
  assign rupt0  = !bus.SQEXT & !bus.SQ0_ & !bus.QC0_ & bus.SQR12_;

  // Gather crosspoint terms; the table itself lives in the package.
  always_comb begin
    xi        = '0;
    xi.t      = ~{bus.T12_, bus.T11_, bus.T10_, bus.T09_, bus.T08_, bus.T07_,
                  bus.T06_, bus.T05_, bus.T04_, bus.T03_, bus.T02_, bus.T01_};
    xi.div    = div;
    xi.st0    = st0_d;
    xi.st1    = st1_d;
    xi.st3    = st3_d;
    xi.st4    = st4_d;
    xi.st376  = st376_d;
    xi.st1376 = st1376_d;
    xi.br1    = br1;
    xi.br2    = br2;
    xi.read0  = cls[0];
    xi.write0 = cls[1];
    xi.rand0  = cls[2];
    xi.wand0  = cls[3];
    xi.ror0   = cls[4];
    xi.wor0   = cls[5];
    xi.rxor0  = cls[6];
    xi.rupt1  = cls[7];
    xi.rupt0  = rupt0;
    xi.geqzro = !bus.GEQZRO_;
    xi.l15    = !bus.L15_;
    xi.sumb16 = !bus.SUMB16_;
    xi.trsm   = bus.TRSM;
    xi.rsm3   = bus.RSM3;
    xi.mp1    = bus.MP1;
    xi.ts0    = !bus.TS0_;
    xi.store1 = !bus.STORE1_;
  end

  assign xo = xp_eval(xi);

  // Stage outputs.
  assign bus.STG1    = stg_bits[0];
  assign bus.STG2    = stg_bits[1];
  assign bus.STG3    = stg_bits[2];
  assign bus.ST0_    = !st0_d;
  assign bus.ST1_    = !st1_d;
  assign bus.ST3_    = !st3_d;
  assign bus.ST4_    = !st4_d;
  assign bus.ST1D    = st1_d & !div;   // stage 1 outside a divide
  assign bus.STD2    = st2_d;
  assign bus.ST376   = st376_d;
  assign bus.ST376_  = !st376_d;
  assign bus.ST1376_ = !st1376_d;

  // Branch outputs.
  assign bus.BR1     = br1;
  assign bus.BR1_    = !br1;
  assign bus.BR2     = br2;
  assign bus.BR2_    = !br2;
  assign bus.BR12B   = !br1 & !br2;
  assign bus.BR12B_  = !(!br1 & !br2);
  assign bus.BR1B2   = br1 & br2;
  assign bus.BR1B2_  = !(br1 & br2);
  assign bus.BR1B2B  = br1 & !br2;
  assign bus.BR1B2B_ = !(br1 & !br2);
  assign bus.BRDIF_  = !(br1 ^ br2);

  // Divide outputs.
  assign bus.DIV_    = !div;
  assign bus.DIVSTG  = divstg;
  assign bus.DV0     = div & st0_d;
  assign bus.DV0_    = !(div & st0_d);
  assign bus.DV1     = div & st1_d;
  assign bus.DV1_    = !(div & st1_d);
  assign bus.DV4     = div & st4_d;
  assign bus.DV4_    = !(div & st4_d);
  assign bus.DV376   = div & st376_d;
  assign bus.DV376_  = !(div & st376_d);
  assign bus.DV1376  = div & st1376_d;
  assign bus.DV1376_ = !(div & st1376_d);
  assign bus.DV3764  = div & st3764_d;
  assign bus.DVST_   = !bus.DVST;

  // Instruction-class outputs.
  assign bus.READ0   = cls[0];
  assign bus.READ0_  = !cls[0];
  assign bus.WRITE0  = cls[1];
  assign bus.WRITE0_ = !cls[1];
  assign bus.RAND0   = cls[2];
  assign bus.WAND0   = cls[3];
  assign bus.ROR0    = cls[4];
  assign bus.WOR0    = cls[5];
  assign bus.WOR0_   = !cls[5];
  assign bus.RXOR0   = cls[6];
  assign bus.RXOR0_  = !cls[6];
  assign bus.RUPT1   = cls[7];
  assign bus.RUPT1_  = !cls[7];
  assign bus.RUPT0   = rupt0;
  assign bus.RUPT0_  = !rupt0;
  assign bus.INOUT   = |cls[6:0];
  assign bus.INOUT_  = !(|cls[6:0]);
  assign bus.PRINC   = !bus.INKL & !bus.SQEXT;
  assign bus.KRPT    = rupt0 & !bus.T09_;

  // Control pulses.
  assign bus.RA_     = !xo.ra;
  assign bus.RB_     = !xo.rb;
  assign bus.RC_     = !xo.rc;
  assign bus.RB1_    = !xo.rb1;
  assign bus.R1C_    = !xo.r1c;
  assign bus.WG_     = !xo.wg;
  assign bus.WL_     = !xo.wl;
  assign bus.WY_     = !xo.wy;
  assign bus.CI_     = !xo.ci;
  assign bus.L16_    = !xo.l16;
  assign bus.RSC_    = !xo.rsc;
  assign bus.WCH_    = !xo.wch;
  assign bus.TMZ_    = !xo.tmz;
  assign bus.TSGN_   = !xo.tsgn;
  assign bus.TSGN2   = xo.tsgn2;
  assign bus.TRSM_   = !xo.trsm;
  assign bus.TL15    = xo.tl15;

  // Monitor copies.
  assign bus.MBR1    = br1;
  assign bus.MBR2    = br2;
  assign bus.MST1    = stg_bits[0];
  assign bus.MST2    = stg_bits[1];
  assign bus.MST3    = stg_bits[2];
  assign bus.MRSC    = xo.rsc;
  assign bus.MP3A    = !bus.MP3_;
  assign bus.MP0T10  = !bus.MP0_ & !bus.T10_;

  // Crosspoint terms.
  assign bus.B15X    = xo.b15x;
  assign bus.R15     = xo.r15;
  assign bus.RB2     = xo.rb2;
  assign bus.RRPA    = xo.rrpa;
  assign bus.SGUM    = xo.sgum;
  assign bus.T12USE_ = !xo.t12use;
  assign bus.d1XP10  = xo.d1xp10;
  assign bus.d2XP3   = xo.d2xp3;
  assign bus.d2XP5   = xo.d2xp5;
  assign bus.d3XP7   = xo.d3xp7;
  assign bus.d5XP4   = xo.d5xp4;
  assign bus.d6XP5   = xo.d6xp5;
  assign bus.d7XP19  = xo.d7xp19;
  assign bus.d8XP6   = xo.d8xp6;
  assign bus.d9XP1   = xo.d9xp1;
  assign bus.d2PP1   = xo.d2pp1;
  assign bus.d8PP4   = xo.d8pp4;

  // Strap and qualifiers this slice of the matrix does not consume.
  assign unused_ok = &{1'b0, bus.CGA4, bus.T01, bus.SQ2_, bus.SQEXT_, bus.SQR10_,
                       bus.QC2_, bus.QC3_, bus.PHS2_, bus.PHS4, bus.PHS4_, bus.EXST0_,
                       bus.EXST1_, bus.IC12, bus.IC13, bus.MTCSAI, bus.NDR100_,
                       bus.RSM3_, bus.XB7_, bus.XT1_, bus.d7XP14};

endmodule

// File: tb/tb_a4_stage_branch.sv
// Directed bench for a4_stage_branch with an expected-value queue.
// Latency: checks state one clock after each stimulus edge, decodes after settling.
// Backpressure: none.
module tb_a4_stage_branch;
  logic CLOCK = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  string       exp_tag[$];
  logic [15:0] exp_val[$];

  logic [15:0] div_seq   [6] = '{16'd1, 16'd3, 16'd7, 16'd6, 16'd4, 16'd0};
  logic [15:0] div_dv376 [6] = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0};

  a4_stage_branch_if bus ();

  a4_stage_branch dut (.CLOCK(CLOCK), .rst(rst), .bus(bus));

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [15:0] v);
    exp_tag.push_back(tag);
    exp_val.push_back(v);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    string       tag;
    logic [15:0] e;
    checks++;
    if (exp_val.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow observed=%h expected=<none>", obs);
    end else begin
      tag = exp_tag.pop_front();
      e   = exp_val.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  function automatic logic [15:0] stg_obs();
    return {13'd0, bus.STG3, bus.STG2, bus.STG1};
  endfunction

  function automatic logic [15:0] br_obs();
    return {14'd0, bus.BR2, bus.BR1};
  endfunction

  function automatic logic [15:0] io_obs();
    return {7'd0, bus.INOUT, bus.RUPT1, bus.RXOR0, bus.WOR0, bus.ROR0,
            bus.WAND0, bus.RAND0, bus.WRITE0, bus.READ0};
  endfunction

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic strobe();
    bus.T12_ = 1'b0; bus.PHS3_ = 1'b0;
    step();
    bus.T12_ = 1'b1; bus.PHS3_ = 1'b1;
  endtask

  task automatic set_wl(input logic [16:1] v);
    {bus.WL16_, bus.WL15_, bus.WL14_, bus.WL13_, bus.WL12_, bus.WL11_, bus.WL10_, bus.WL09_,
     bus.WL08_, bus.WL07_, bus.WL06_, bus.WL05_, bus.WL04_, bus.WL03_, bus.WL02_, bus.WL01_} = v;
  endtask

  task automatic idle();
    bus.CGA4 = 1; bus.DVST = 0; bus.GOJAM = 0; bus.RSTSTG = 0; bus.STRTFC = 0;
    bus.SQ0_ = 1; bus.SQ1_ = 1; bus.SQ2_ = 1; bus.SQEXT = 0; bus.SQEXT_ = 1;
    bus.SQR10 = 0; bus.SQR10_ = 1; bus.SQR12_ = 1;
    bus.QC0_ = 1; bus.QC1_ = 1; bus.QC2_ = 1; bus.QC3_ = 1;
    bus.T01 = 0; bus.T01_ = 1; bus.T02_ = 1; bus.T03_ = 1; bus.T04_ = 1; bus.T05_ = 1;
    bus.T06_ = 1; bus.T07_ = 1; bus.T08_ = 1; bus.T09_ = 1; bus.T10_ = 1; bus.T11_ = 1; bus.T12_ = 1;
    bus.PHS2_ = 1; bus.PHS3_ = 1; bus.PHS4 = 0; bus.PHS4_ = 1; bus.ST1 = 0; bus.ST2 = 0;
    bus.SUMA16_ = 1; bus.SUMB16_ = 1; bus.OVF_ = 1; bus.UNF_ = 1; bus.GEQZRO_ = 1; bus.L15_ = 1;
    bus.TOV_ = 1; bus.TPZG_ = 1; bus.TSGU_ = 1;
    set_wl(16'hFFFF);
    bus.EXST0_ = 1; bus.EXST1_ = 1; bus.IC12 = 0; bus.IC13 = 0; bus.INKL = 0;
    bus.MP0_ = 1; bus.MP1 = 0; bus.MP3_ = 1; bus.MTCSAI = 0; bus.NDR100_ = 1;
    bus.RSM3 = 0; bus.RSM3_ = 1; bus.STORE1_ = 1; bus.TRSM = 0; bus.TS0_ = 1;
    bus.XB7_ = 1; bus.XT1_ = 1; bus.d7XP14 = 0;
  endtask

  initial begin
    logic [15:0] e;
    idle();
    rst = 1'b1;

    // Reset state.
    push("rst_stg", 16'd0); push("rst_br", 16'd0); push("rst_st0_n", 16'd0);
    push("rst_br12b", 16'd1); push("rst_io", 16'd0);
    step();
    rst = 1'b0;
    pop_check(stg_obs()); pop_check(br_obs()); pop_check(16'(bus.ST0_));
    pop_check(16'(bus.BR12B)); pop_check(io_obs());

    // Stage request without a strobe must not move the counter.
    bus.ST1 = 1;
    push("hold_no_ss", 16'd0);
    step();
    pop_check(stg_obs());

    push("st1_stg", 16'd1); push("st1_n", 16'd0);
    strobe();
    pop_check(stg_obs()); pop_check(16'(bus.ST1_));

    bus.ST1 = 0; bus.ST2 = 1;
    push("st2_stg", 16'd2);
    strobe();
    pop_check(stg_obs());

    bus.STRTFC = 1;
    push("strtfc_stg", 16'd0);
    strobe();
    pop_check(stg_obs());
    bus.STRTFC = 0; bus.ST2 = 0; bus.ST1 = 1;

    push("st1_again", 16'd1);
    strobe();
    pop_check(stg_obs());

    bus.GOJAM = 1;
    push("gojam_stg", 16'd0);
    strobe();
    pop_check(stg_obs());
    bus.GOJAM = 0; bus.ST1 = 0;

    // Divide sequence.
    bus.SQEXT = 1; bus.SQEXT_ = 0; bus.SQ1_ = 0; bus.QC0_ = 0; bus.DVST = 1;
    push("div_n", 16'd0); push("divstg_s0", 16'd1);
    #1;
    pop_check(16'(bus.DIV_)); pop_check(16'(bus.DIVSTG));
    bus.T01_ = 0;
    push("tsgn_n", 16'd0);
    #1;
    pop_check(16'(bus.TSGN_));
    bus.T01_ = 1;

    for (int k = 0; k < 6; k++) begin
      push($sformatf("div_stg%0d", k), div_seq[k]);
      push($sformatf("div_dv376_%0d", k), div_dv376[k]);
      strobe();
      pop_check(stg_obs());
      pop_check(16'(bus.DV376));
    end

    strobe();
    strobe();
    bus.T02_ = 0;
    push("d2xp3_st3", 16'd1);
    #1;
    pop_check(16'(bus.d2XP3));
    bus.T02_ = 1;
    push("div_at7", 16'd7);
    strobe();
    pop_check(stg_obs());

    rst = 1'b1;
    push("rst_mid_stg", 16'd0); push("rst_mid_dv0", 16'd1);
    step();
    rst = 1'b0;
    pop_check(stg_obs()); pop_check(16'(bus.DV0));

    bus.SQEXT = 0; bus.SQEXT_ = 1; bus.SQ1_ = 1; bus.QC0_ = 1; bus.DVST = 0;

    // Branch flops.
    bus.TOV_ = 0; bus.OVF_ = 0; bus.UNF_ = 1;
    push("tov_br", 16'b01); push("tov_br1b2b", 16'd1);
    step();
    bus.TOV_ = 1; bus.OVF_ = 1;
    pop_check(br_obs()); pop_check(16'(bus.BR1B2B));

    bus.TPZG_ = 0;
    push("tpzg_br", 16'b11); push("tpzg_br1b2", 16'd1); push("brdif_n_same", 16'd1);
    step();
    bus.TPZG_ = 1;
    pop_check(br_obs()); pop_check(16'(bus.BR1B2)); pop_check(16'(bus.BRDIF_));

    set_wl(16'hFFFB);
    bus.TPZG_ = 0;
    push("tpzg_nonzero", 16'b01); push("brdif_n_diff", 16'd0);
    step();
    bus.TPZG_ = 1;
    set_wl(16'hFFFF);
    pop_check(br_obs()); pop_check(16'(bus.BRDIF_));

    bus.TOV_ = 0; bus.OVF_ = 0; bus.UNF_ = 0; bus.TSGU_ = 0; bus.SUMA16_ = 1;
    push("tsgu_over_tov", 16'b10);
    step();
    bus.TSGU_ = 1;
    pop_check(br_obs());

    bus.GOJAM = 1;
    push("gojam_br", 16'd0); push("gojam_br12b", 16'd1);
    step();
    bus.GOJAM = 0; bus.TOV_ = 1; bus.OVF_ = 1; bus.UNF_ = 1;
    pop_check(br_obs()); pop_check(16'(bus.BR12B));

    // Peripheral class sweep.
    bus.SQEXT = 1; bus.SQEXT_ = 0; bus.SQ0_ = 0;
    for (int i = 0; i < 8; i++) begin
      bus.QC1_ = ~i[2]; bus.QC0_ = ~i[1]; bus.SQR10 = i[0]; bus.SQR10_ = ~i[0];
      e = 16'(1 << i);
      if (i < 7) e[8] = 1'b1;
      push($sformatf("io_class%0d", i), e);
      #1;
      pop_check(io_obs());
    end
    push("inout_n_rupt1", 16'd1);
    pop_check(16'(bus.INOUT_));

    // Interrupt and PRINC decodes.
    bus.SQEXT = 0; bus.SQEXT_ = 1; bus.SQ0_ = 0; bus.QC0_ = 0; bus.QC1_ = 1;
    bus.SQR10 = 0; bus.SQR10_ = 1;
    push("rupt0", 16'd1); push("krpt_no_t09", 16'd0); push("princ", 16'd1);
    #1;
    pop_check(16'(bus.RUPT0)); pop_check(16'(bus.KRPT)); pop_check(16'(bus.PRINC));
    bus.T09_ = 0;
    push("krpt_t09", 16'd1); push("d9xp1", 16'd1);
    #1;
    pop_check(16'(bus.KRPT)); pop_check(16'(bus.d9XP1));
    bus.T09_ = 1; bus.INKL = 1;
    push("princ_inkl", 16'd0);
    #1;
    pop_check(16'(bus.PRINC));

    checks++;
    assert (exp_val.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", exp_val.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
